// File: rtl/st_arb_pkg.sv
// Shared types and constants for the packet-granular Avalon-ST arbiter.
package st_arb_pkg;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefDataW  = 32;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } arb_state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int unsigned grant_w(input int unsigned num_req);
    int unsigned w;
    w = 1;
    if (num_req > 1) begin
      w = unsigned'($clog2(num_req));
    end
    return w;
  endfunction

endpackage

// File: rtl/st_rr_pick.sv
// Combinational rotate-priority picker: first eligible index at or after ptr_i, wrapping.
module st_rr_pick
  import st_arb_pkg::*;
#(
  parameter int unsigned NumReq = DefNumReq,
  parameter int unsigned IdxW   = grant_w(NumReq)
) (
  input  logic [NumReq-1:0] elig_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  int unsigned      pos;
  logic [IdxW-1:0]  cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos  = (32'(ptr_i) + k) % NumReq;
      cand = IdxW'(pos);
      if (!found_o && elig_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/st_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one Avalon-ST sink; grant held until EOP accepted.
// Optional per-requester packet counters are built when ST_ARB_PKT_COUNT_EN is defined.
module st_packet_arbiter
  import st_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_startofpacket,
  input  logic [NUM_REQ-1:0]          req_endofpacket,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        source0_valid,
  output logic                        source0_startofpacket,
  output logic                        source0_endofpacket,
  output logic [DATA_W-1:0]           source0_data,
  input  logic                        source0_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef ST_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]    pkt_count
`endif
);

  localparam int unsigned GrantW = grant_w(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [GrantW-1:0]  grant_q, grant_d;
  logic [GrantW-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic [GrantW-1:0]  pick_idx;
  logic               pick_found;
  logic               beat_acc;
  logic               eop_acc;

  // Only a SOP beat may open a packet; a valid without SOP in idle just stalls.
  assign elig = req_valid & req_startofpacket;

  st_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (GrantW)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // No data register: the downstream pipeline stage does the registering.
  always_comb begin
    source0_valid         = 1'b0;
    source0_startofpacket = 1'b0;
    source0_endofpacket   = 1'b0;
    source0_data          = '0;
    req_ready             = '0;
    if (state_q == StLock) begin
      source0_valid          = req_valid[grant_q];
      source0_startofpacket  = req_startofpacket[grant_q];
      source0_endofpacket    = req_endofpacket[grant_q];
      source0_data           = req_data[grant_q*DATA_W +: DATA_W];
      req_ready[grant_q]     = source0_ready;
    end
  end

  assign beat_acc = source0_valid & source0_ready;
  assign eop_acc  = beat_acc & source0_endofpacket;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StLock;
          grant_d = pick_idx;
        end
      end
      StLock: begin
        if (eop_acc) begin
          state_d = StIdle;
          ptr_d   = (grant_q == GrantW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == StLock);

`ifdef ST_ARB_PKT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (eop_acc) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_st_packet_arbiter.sv
// Bench for st_packet_arbiter: cycle table, queue-driven requesters and an ordered beat scoreboard.
module tb_st_packet_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned GW = 2;

  logic                 clk;
  logic                 reset_reset;
  logic [NR-1:0]        req_valid, req_sop, req_eop, req_ready;
  logic [NR*DW-1:0]     req_data;
  logic                 src_valid, src_sop, src_eop, src_ready;
  logic [DW-1:0]        src_data;
  logic [GW-1:0]        grant_id;
  logic                 busy;
`ifdef ST_ARB_PKT_COUNT_EN
  logic [NR*CW-1:0]     pkt_count;
`endif

  st_packet_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk_clk               (clk),
    .reset_reset           (reset_reset),
    .req_valid             (req_valid),
    .req_startofpacket     (req_sop),
    .req_endofpacket       (req_eop),
    .req_data              (req_data),
    .req_ready             (req_ready),
    .source0_valid         (src_valid),
    .source0_startofpacket (src_sop),
    .source0_endofpacket   (src_eop),
    .source0_data          (src_data),
    .source0_ready         (src_ready),
    .grant_id              (grant_id),
    .busy                  (busy)
`ifdef ST_ARB_PKT_COUNT_EN
    ,
    .pkt_count             (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [DW+1:0] beat_t;  // {sop, eop, data}

  typedef struct {
    logic [NR-1:0]    v, s, e;
    logic [NR*DW-1:0] d;
    logic             rdy;
    logic             x_valid, x_sop, x_eop;
    logic [DW-1:0]    x_data;
    logic [NR-1:0]    x_ready;
    logic             x_busy;
    logic [GW-1:0]    x_grant;
  } vec_t;

  beat_t rq[NR][$];
  beat_t sb[$];
  int    n_chk, n_fail;
  int    cyc, last_acc_cyc;
  bit    last_eop, chk_gap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic [NR-1:0] v, input logic [NR-1:0] s,
                               input logic [NR-1:0] e, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic rdy, input logic xv, input logic xs,
                               input logic xe, input logic [DW-1:0] xd,
                               input logic [NR-1:0] xr, input logic xb,
                               input logic [GW-1:0] xg);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.d = {32'h0, d2, d1, d0}; t.rdy = rdy;
    t.x_valid = xv; t.x_sop = xs; t.x_eop = xe; t.x_data = xd;
    t.x_ready = xr; t.x_busy = xb; t.x_grant = xg;
    return t;
  endfunction

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic apply_heads();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0) begin
        b = rq[i][0];
        req_valid[i] = 1'b1;
        req_sop[i]   = b[DW+1];
        req_eop[i]   = b[DW];
        req_data[i*DW +: DW] = b[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_sop[i]   = 1'b0;
        req_eop[i]   = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock of queue-driven stimulus with scoreboard and ready checks at the negedge.
  task automatic step(input logic rdy);
    logic [NR-1:0] acc;
    beat_t         exp_b;
    src_ready = rdy;
    apply_heads();
    @(negedge clk);
    if (src_valid && src_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(src_data), 64'hdead);
      end else begin
        exp_b = sb.pop_front();
        check("beat", 64'({src_sop, src_eop, src_data}), 64'(exp_b));
        if (chk_gap && src_sop && last_eop)
          check("pkt_gap", 64'(cyc - last_acc_cyc), 64'd2);
        else if (chk_gap && !src_sop)
          check("beat_gap", 64'(cyc - last_acc_cyc), 64'd1);
        last_acc_cyc = cyc;
        last_eop     = src_eop;
      end
    end
    if (busy) begin
      check("ready_track", 64'(req_ready[grant_id]), 64'(src_ready));
      check("ready_others", 64'(req_ready & ~(4'b0001 << grant_id)), 64'd0);
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(rq[i].pop_front());
    end
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    int k;
    k = 0;
    chk_gap = !toggle;
    while (k < budget && !(queues_empty() && sb.size() == 0)) begin
      step(toggle ? (k % 2 == 0) : 1'b1);
      k++;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_req", 64'(queues_empty()), 64'd1);
  endtask

  task automatic push_beat(input int r, input logic sop, input logic eop, input logic [DW-1:0] d);
    rq[r].push_back({sop, eop, d});
    sb.push_back({sop, eop, d});
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0; src_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc++;
    reset_reset = 1'b0;
    last_eop = 1'b0;
  endtask

  vec_t tv[12];
  int   ord[5];

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_acc_cyc = 0; last_eop = 1'b0; chk_gap = 1'b1;
    tv[0]  = mkv(4'b0001, 4'b0001, 4'b0000, 32'hA0, 32'h0, 32'h0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
    tv[1]  = mkv(4'b0001, 4'b0001, 4'b0000, 32'hA0, 32'h0, 32'h0, 1'b1,
                 1'b1, 1'b1, 1'b0, 32'hA0, 4'b0001, 1'b1, 2'd0);
    tv[2]  = mkv(4'b0001, 4'b0000, 4'b0000, 32'hA1, 32'h0, 32'h0, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'hA1, 4'b0001, 1'b1, 2'd0);
    tv[3]  = mkv(4'b0001, 4'b0000, 4'b0001, 32'hA2, 32'h0, 32'h0, 1'b1,
                 1'b1, 1'b0, 1'b1, 32'hA2, 4'b0001, 1'b1, 2'd0);
    tv[4]  = mkv(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
    tv[5]  = mkv(4'b0011, 4'b0011, 4'b0011, 32'hB0, 32'hB1, 32'h0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
    tv[6]  = mkv(4'b0011, 4'b0011, 4'b0011, 32'hB0, 32'hB1, 32'h0, 1'b1,
                 1'b1, 1'b1, 1'b1, 32'hB1, 4'b0010, 1'b1, 2'd1);
    tv[7]  = mkv(4'b0001, 4'b0001, 4'b0001, 32'hB0, 32'h0, 32'h0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd1);
    tv[8]  = mkv(4'b0001, 4'b0001, 4'b0001, 32'hB0, 32'h0, 32'h0, 1'b0,
                 1'b1, 1'b1, 1'b1, 32'hB0, 4'b0000, 1'b1, 2'd0);
    tv[9]  = mkv(4'b0001, 4'b0001, 4'b0001, 32'hB0, 32'h0, 32'h0, 1'b1,
                 1'b1, 1'b1, 1'b1, 32'hB0, 4'b0001, 1'b1, 2'd0);
    tv[10] = mkv(4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'hC0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
    tv[11] = mkv(4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'hC0, 1'b1,
                 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);

    // Reset state with idle inputs
    do_reset();
    @(negedge clk);
    check("rst_valid", 64'(src_valid), 64'd0);
    check("rst_sop_eop", 64'({src_sop, src_eop}), 64'd0);
    check("rst_data", 64'(src_data), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
`ifdef ST_ARB_PKT_COUNT_EN
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    cyc++;

    // Cycle table: 3-beat packet, pointer advance, ready stall, valid without SOP
    for (int i = 0; i < 12; i++) begin
      req_valid = tv[i].v; req_sop = tv[i].s; req_eop = tv[i].e;
      req_data = tv[i].d; src_ready = tv[i].rdy;
      @(negedge clk);
      check($sformatf("tv%0d_valid", i), 64'(src_valid), 64'(tv[i].x_valid));
      check($sformatf("tv%0d_sop", i), 64'(src_sop), 64'(tv[i].x_sop));
      check($sformatf("tv%0d_eop", i), 64'(src_eop), 64'(tv[i].x_eop));
      check($sformatf("tv%0d_data", i), 64'(src_data), 64'(tv[i].x_data));
      check($sformatf("tv%0d_ready", i), 64'(req_ready), 64'(tv[i].x_ready));
      check($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].x_busy));
      check($sformatf("tv%0d_grant", i), 64'(grant_id), 64'(tv[i].x_grant));
      @(posedge clk);
      #1;
      cyc++;
    end

    // Four requesters with 2-beat packets: order 0,1,2,3,0 with one idle cycle between
    do_reset();
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    for (int p = 0; p < 5; p++) begin
      push_beat(ord[p], 1'b1, 1'b0, 32'hD000 + 32'(p * 16));
      push_beat(ord[p], 1'b0, 1'b1, 32'hD001 + 32'(p * 16));
    end
    run_until_done(60, 1'b0);

    // Ready toggling during a 4-beat packet from req2
    last_eop = 1'b0;
    push_beat(2, 1'b1, 1'b0, 32'hE20);
    push_beat(2, 1'b0, 1'b0, 32'hE21);
    push_beat(2, 1'b0, 1'b0, 32'hE22);
    push_beat(2, 1'b0, 1'b1, 32'hE23);
    run_until_done(40, 1'b1);

    // Reset during the second beat of a req1 packet; pointer must restart at 0
    last_eop = 1'b0;
    chk_gap  = 1'b1;
    push_beat(1, 1'b1, 1'b0, 32'hC10);
    push_beat(1, 1'b0, 1'b0, 32'hC11);
    rq[1].push_back({1'b0, 1'b1, 32'hC12});
    for (int k = 0; k < 10 && sb.size() > 1; k++) step(1'b1);
    check("c10_accepted", 64'(sb.size()), 64'd1);
    reset_reset = 1'b1;
    step(1'b1);
    reset_reset = 1'b0;
    rq[1].delete();
    apply_heads();
    @(negedge clk);
    check("post_rst_valid", 64'(src_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_grant", 64'(grant_id), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    last_eop = 1'b0;
    push_beat(0, 1'b1, 1'b1, 32'hF0);
    push_beat(1, 1'b1, 1'b1, 32'hF1);
    push_beat(3, 1'b1, 1'b1, 32'hF3);
    run_until_done(40, 1'b0);

`ifdef ST_ARB_PKT_COUNT_EN
    // Five packets from req3 wrap a 2-bit counter to 1
    do_reset();
    for (int p = 0; p < 5; p++) push_beat(3, 1'b1, 1'b1, 32'h300 + 32'(p));
    run_until_done(60, 1'b0);
    check("cnt3", 64'(pkt_count[3*CW +: CW]), 64'd1);
    check("cnt_others", 64'(pkt_count[3*CW-1:0]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
